// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 codes, requester ids, helpers.
// Latency: none; pure declarations and combinational functions.
// Backpressure: not applicable.
package dmem_arb_pkg;

    // Width of the DMA starvation counter; sized for DMA_MAX_WAIT up to 15.
    localparam int DMA_WAIT_W = 4;

    // RV32 load funct3 codes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32 store funct3 codes.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_id_e;

    // Request header without the data word, which is parameter-sized.
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic        we;
    } req_hdr_t;

    // True when the funct3 code exists for this direction and the address is
    // naturally aligned for the access size.
    function automatic logic access_legal(input logic [2:0] funct3,
                                          input logic       we,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_LB:   ok = 1'b1;                        // also F3_SB
            F3_LH:   ok = !addr_lo[0];                 // also F3_SH
            F3_LW:   ok = (addr_lo == 2'b00);          // also F3_SW
            F3_LBU:  ok = !we;
            F3_LHU:  ok = !we && !addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The memory only sees signed sizes; extension happens on the way back.
    function automatic logic [2:0] mem_funct3_map(input logic [2:0] funct3);
        logic [2:0] f;
        case (funct3)
            F3_LBU:  f = F3_LB;
            F3_LHU:  f = F3_LH;
            default: f = funct3;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/halfword lane of a memory word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none; follows the inputs every cycle.
module dmem_load_align
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] raw_data,
    input  logic [1:0]        byte_off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane select then extension by access type; word loads pass through untouched.
    always_comb begin
        lane_byte = raw_data[{byte_off, 3'b000} +: 8];
        lane_half = raw_data[{byte_off[1], 4'b0000} +: 16];
        load_data = raw_data;
        case (funct3)
            F3_LB:   load_data = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
            F3_LH:   load_data = {{(DATA_W-16){lane_half[15]}}, lane_half};
            F3_LBU:  load_data = {{(DATA_W-8){1'b0}}, lane_byte};
            F3_LHU:  load_data = {{(DATA_W-16){1'b0}}, lane_half};
            default: load_data = raw_data;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (core, DMA) data-memory arbiter with funct3 legality checks; DMA port active only with DMEM_ARB_DMA_EN.
// Latency: mem_* combinational in the grant cycle; response one cycle after the grant.
// Backpressure: req_ready only for the granted requester; core has priority unless DMA has waited DMA_MAX_WAIT cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DMA_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_funct3,
    input  logic              core_we,
    output logic              core_rsp_valid,
    output logic              core_rsp_err,
    output logic [DATA_W-1:0] core_rsp_rdata,

    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic [31:0]       dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [2:0]        dma_funct3,
    input  logic              dma_we,
    output logic              dma_rsp_valid,
    output logic              dma_rsp_err,
    output logic [DATA_W-1:0] dma_rsp_rdata,

    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [2:0]        mem_funct3,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    req_hdr_t          core_hdr;
    req_hdr_t          dma_hdr;
    req_hdr_t          gnt_hdr;
    logic [DATA_W-1:0] gnt_wdata;
    req_id_e           gnt_id;
    logic              core_vld;
    logic              core_gnt;
    logic              dma_gnt;
    logic              any_gnt;
    logic              gnt_legal;
    logic [DATA_W-1:0] ld_data;

    logic              rsp_valid_d, rsp_valid_q;
    logic              rsp_err_d,   rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
    req_id_e           rsp_id_d,    rsp_id_q;

    // Valids are masked while reset is held so nothing can be granted then.
    assign core_vld = core_req_valid & rst_n;
    assign core_hdr = '{addr: core_addr, funct3: core_funct3, we: core_we};
    assign dma_hdr  = '{addr: dma_addr,  funct3: dma_funct3,  we: dma_we};

`ifdef DMEM_ARB_DMA_EN
    localparam logic [DMA_WAIT_W-1:0] WAIT_MAX = DMA_WAIT_W'(DMA_MAX_WAIT);

    logic                  dma_vld;
    logic [DMA_WAIT_W-1:0] dma_wait_d, dma_wait_q;

    assign dma_vld = dma_req_valid & rst_n;

    // Core first, unless the DMA has stalled long enough to be owed this slot.
    always_comb begin
        dma_gnt  = dma_vld && (!core_vld || (dma_wait_q == WAIT_MAX));
        core_gnt = core_vld && !dma_gnt;
    end

    // Count consecutive DMA stall cycles; any grant or dropped valid restarts it.
    always_comb begin
        dma_wait_d = '0;
        if (dma_vld && !dma_gnt) begin
            dma_wait_d = (dma_wait_q == WAIT_MAX) ? dma_wait_q
                                                  : dma_wait_q + DMA_WAIT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_wait_q <= '0;
        end else begin
            dma_wait_q <= dma_wait_d;
        end
    end

    assign dma_req_ready = dma_gnt;
`else
    // DMA port is inert in this build; its request inputs are deliberately ignored.
    logic                  unused_dma_vld;
    logic [DMA_WAIT_W-1:0] unused_dma_max;

    assign unused_dma_vld = dma_req_valid;
    assign unused_dma_max = DMA_WAIT_W'(DMA_MAX_WAIT);

    // Core owns the memory whenever it asks.
    always_comb begin
        dma_gnt  = 1'b0;
        core_gnt = core_vld;
    end

    assign dma_req_ready = 1'b0;
`endif

    assign core_req_ready = core_gnt;
    assign any_gnt        = core_gnt | dma_gnt;

    // Route the winning request onto the shared datapath.
    always_comb begin
        gnt_hdr   = core_hdr;
        gnt_wdata = core_wdata;
        gnt_id    = REQ_CORE;
        if (dma_gnt) begin
            gnt_hdr   = dma_hdr;
            gnt_wdata = dma_wdata;
            gnt_id    = REQ_DMA;
        end
    end

    assign gnt_legal = any_gnt && access_legal(gnt_hdr.funct3, gnt_hdr.we, gnt_hdr.addr[1:0]);

    // Memory drive; illegal or absent grants raise no strobe.
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_funct3     = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (any_gnt) begin
            mem_address    = gnt_hdr.addr;
            mem_write_data = gnt_wdata;
            mem_funct3     = mem_funct3_map(gnt_hdr.funct3);
            mem_write      = gnt_legal && gnt_hdr.we;
            mem_read       = gnt_legal && !gnt_hdr.we;
        end
    end

    dmem_load_align #(
        .DATA_W    (DATA_W)
    ) u_load_align (
        .raw_data  (mem_read_data),
        .byte_off  (gnt_hdr.addr[1:0]),
        .funct3    (gnt_hdr.funct3),
        .load_data (ld_data)
    );

    // Every grant yields exactly one response next cycle; only legal loads carry data.
    always_comb begin
        rsp_valid_d = any_gnt;
        rsp_err_d   = any_gnt && !gnt_legal;
        rsp_id_d    = gnt_id;
        rsp_rdata_d = '0;
        if (gnt_legal && !gnt_hdr.we) begin
            rsp_rdata_d = ld_data;
        end
    end

    // Response register; reset drops any response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_id_q    <= REQ_CORE;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign core_rsp_valid = rsp_valid_q && (rsp_id_q == REQ_CORE);
    assign core_rsp_err   = core_rsp_valid && rsp_err_q;
    assign core_rsp_rdata = core_rsp_valid ? rsp_rdata_q : '0;

`ifdef DMEM_ARB_DMA_EN
    assign dma_rsp_valid = rsp_valid_q && (rsp_id_q == REQ_DMA);
    assign dma_rsp_err   = dma_rsp_valid && rsp_err_q;
    assign dma_rsp_rdata = dma_rsp_valid ? rsp_rdata_q : '0;
`else
    assign dma_rsp_valid = 1'b0;
    assign dma_rsp_err   = 1'b0;
    assign dma_rsp_rdata = '0;
`endif

endmodule
